pomdp_state_sampler: RTL and testbench



---
 rtl/pomdp_state_sampler.sv | 197 +++++++++++++++++++
 tb/tb_pomdp_state_sampler.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pomdp_state_sampler.sv
`default_nettype none
// ============================================================================
// Module      : pomdp_state_sampler
// Description : Next-state sampler for the PBVI/POMDP engine. Takes an action,
//               the current state and a uniform random word, then scans the
//               selected row of the transition table with a running cumulative
//               sum, one entry per cycle. The first entry at which the random
//               word is below the sum is the sampled next state. If the row
//               sum never exceeds the random word, the last state is returned.
//
// Ports       : clk        - sole clock, rising edge
//               rst        - synchronous, active-high reset
//               start      - request pulse, sampled only while idle
//               action     - action index, latched at start
//               state      - current state, latched at start
//               random     - uniform random word, latched at start
//               trans      - trans[a][s][n] = P(n | s, a), held stable while busy
//               busy       - scan in progress
//               done       - one-cycle pulse, new_state valid
//               new_state  - sampled next state, held until the next done
//
// Options     : STATE_SAMPLER_FIXED_LAT_EN - when defined, every scan walks the
//               whole row so done always arrives NUM_STATES+1 cycles after
//               start; the first matching index is still the result.
//
// Revision    : 1.0 - initial release
// ============================================================================
module pomdp_state_sampler #(
  parameter int NUM_STATES  = 4,
  parameter int NUM_ACTIONS = 3,
  parameter int PROB_W      = 16,
  localparam int AW = (NUM_ACTIONS > 1) ? $clog2(NUM_ACTIONS) : 1,
  localparam int SW = $clog2(NUM_STATES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [AW-1:0]         action,
  input  logic [SW-1:0]         state,
  input  logic [PROB_W-1:0]     random,
  input  logic [NUM_ACTIONS-1:0][NUM_STATES-1:0][NUM_STATES-1:0][PROB_W-1:0] trans,
  output logic                  busy,
  output logic                  done,
  output logic [SW-1:0]         new_state
);

  // The accumulator carries SW extra bits so a full row of maximum entries
  // can never wrap around.
  localparam int              ACC_W    = PROB_W + SW;
  localparam logic [SW-1:0]   LAST_IDX = SW'(NUM_STATES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        fsm_q, fsm_d;
  logic [AW-1:0]     act_q;
  logic [SW-1:0]     st_q;
  logic [PROB_W-1:0] rnd_q;
  logic [SW-1:0]     idx_q, idx_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [SW-1:0]     new_state_q, new_state_d;

  logic              load;
  logic [PROB_W-1:0] entry;
  logic [ACC_W-1:0]  sum;
  logic              hit;
  logic              last;

`ifdef STATE_SAMPLER_FIXED_LAT_EN
  // Remembers the first matching index while the scan continues to the end.
  logic              found_q, found_d;
  logic [SW-1:0]     sel_q, sel_d;
`endif

  assign load  = (fsm_q == ST_IDLE) && start;
  assign entry = trans[act_q][st_q][idx_q];
  assign sum   = acc_q + ACC_W'(entry);
  assign hit   = (ACC_W'(rnd_q) < sum);
  assign last  = (idx_q == LAST_IDX);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= ST_IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath update
  // --------------------------------------------------------------------------
  always_comb begin
    fsm_d       = fsm_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    new_state_d = new_state_q;
`ifdef STATE_SAMPLER_FIXED_LAT_EN
    found_d     = found_q;
    sel_d       = sel_q;
`endif
    case (fsm_q)
      ST_IDLE: begin
        if (start) begin
          fsm_d   = ST_SCAN;
          idx_d   = '0;
          acc_d   = '0;
`ifdef STATE_SAMPLER_FIXED_LAT_EN
          found_d = 1'b0;
          sel_d   = '0;
`endif
        end
      end
      ST_SCAN: begin
`ifdef STATE_SAMPLER_FIXED_LAT_EN
        if (hit && !found_q) begin
          found_d = 1'b1;
          sel_d   = idx_q;
        end
        if (last) begin
          fsm_d = ST_DONE;
          // With no earlier match the last index is both the current hit
          // candidate and the fallback, so idx_q covers both cases.
          new_state_d = found_q ? sel_q : idx_q;
        end else begin
          acc_d = sum;
          idx_d = idx_q + SW'(1);
        end
`else
        if (hit || last) begin
          fsm_d       = ST_DONE;
          new_state_d = idx_q;
        end else begin
          acc_d = sum;
          idx_d = idx_q + SW'(1);
        end
`endif
      end
      ST_DONE: begin
        fsm_d = ST_IDLE;
      end
      default: begin
        fsm_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs decoded from the state register
  // --------------------------------------------------------------------------
  always_comb begin
    busy = (fsm_q == ST_SCAN);
    done = (fsm_q == ST_DONE);
  end

  assign new_state = new_state_q;

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      act_q       <= '0;
      st_q        <= '0;
      rnd_q       <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      new_state_q <= '0;
    end else begin
      if (load) begin
        act_q <= action;
        st_q  <= state;
        rnd_q <= random;
      end
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      new_state_q <= new_state_d;
    end
  end

`ifdef STATE_SAMPLER_FIXED_LAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      found_q <= 1'b0;
      sel_q   <= '0;
    end else begin
      found_q <= found_d;
      sel_q   <= sel_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pomdp_state_sampler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pomdp_state_sampler
// Description : Scoreboard bench for pomdp_state_sampler. The driver predicts
//               each accepted request (sampled state and done cycle) from a
//               cumulative-probability model and queues it; a monitor checks
//               busy, done and new_state every cycle against the queue head.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pomdp_state_sampler;

  localparam int N = 4;
  localparam int A = 3;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst    = 1'b1;
  logic         start  = 1'b0;
  logic [1:0]   action = '0;
  logic [1:0]   state  = '0;
  logic [W-1:0] random = '0;
  logic [A-1:0][N-1:0][N-1:0][W-1:0] trans = '0;
  logic         busy;
  logic         done;
  logic [1:0]   new_state;

  pomdp_state_sampler #(
    .NUM_STATES (N),
    .NUM_ACTIONS(A),
    .PROB_W     (W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .action   (action),
    .state    (state),
    .random   (random),
    .trans    (trans),
    .busy     (busy),
    .done     (done),
    .new_state(new_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int ns;   // expected sampled state
    int acc;  // cycle in which start was accepted
    int dn;   // cycle in which done must be high
  } exp_t;

  exp_t sb[$];
  int   n_assert  = 0;
  int   n_fail    = 0;
  int   last_ns   = 0;
  int   next_idle = 0;

  // Inverse-CDF draw: first n whose cumulative probability exceeds r.
  function automatic int model_pick(int a, int s, int r);
    longint cum = 0;
    for (int n = 0; n < N; n++) begin
      cum += longint'(trans[a][s][n]);
      if (longint'(r) < cum) return n;
    end
    return N - 1;
  endfunction

  function automatic int model_lat(int k);
`ifdef STATE_SAMPLER_FIXED_LAT_EN
    return N + 1 + (k - k);
`else
    return k + 2;
`endif
  endfunction

  task automatic chk(string nm, int got, int want);
    n_assert++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // Monitor: decoupled from stimulus, compares against the scoreboard head.
  always @(negedge clk) begin
    bit exp_busy;
    bit exp_done;
    if (rst) begin
      sb.delete();
      last_ns = 0;
    end else begin
      exp_busy = 1'b0;
      exp_done = 1'b0;
      if (sb.size() > 0) begin
        exp_busy = (cyc > sb[0].acc) && (cyc < sb[0].dn);
        exp_done = (cyc == sb[0].dn);
      end
      chk("busy", int'(busy), int'(exp_busy));
      chk("done", int'(done), int'(exp_done));
      if (busy && done) chk("busy_done_overlap", 1, 0);
      if (done && sb.size() > 0) begin
        chk("new_state", int'(new_state), sb[0].ns);
        last_ns = sb[0].ns;
        void'(sb.pop_front());
      end else if (!done) begin
        chk("new_state_hold", int'(new_state), last_ns);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle; a start is accepted only when the model says idle.
  task automatic issue(bit st, int a, int s, int r);
    int   k;
    exp_t e;
    start  = st;
    action = 2'(a);
    state  = 2'(s);
    random = W'(r);
    if (st && cyc >= next_idle) begin
      k     = model_pick(a, s, r);
      e.ns  = k;
      e.acc = cyc;
      e.dn  = cyc + model_lat(k);
      sb.push_back(e);
      next_idle = e.dn + 1;
    end
    step();
  endtask

  // While busy, toggle start and scramble the request inputs: all ignored.
  task automatic wait_idle();
    while (cyc < next_idle)
      issue(1'($urandom_range(0, 1)), $urandom_range(0, 2),
            $urandom_range(0, 3), $urandom_range(0, 65535));
    start = 1'b0;
  endtask

  task automatic row_const(int a, int s, int v);
    for (int n = 0; n < N; n++) trans[a][s][n] = W'(v);
  endtask

  task automatic randomize_table();
    int mode;
    mode = $urandom_range(0, 2);
    for (int a = 0; a < A; a++)
      for (int s = 0; s < N; s++)
        for (int n = 0; n < N; n++)
          case (mode)
            0:       trans[a][s][n] = W'($urandom_range(0, 16384));
            1:       trans[a][s][n] = W'($urandom_range(0, 65535));
            default: trans[a][s][n] = ($urandom_range(0, 2) == 0) ? W'(0)
                                                                   : W'($urandom_range(0, 40000));
          endcase
  endtask

  initial begin
    int r;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    next_idle = cyc;

    // Directed row of four equal quarters.
    row_const(1, 2, 'h4000);
    issue(1'b1, 1, 2, 'h3FFF);
    wait_idle(); issue(1'b1, 1, 2, 'h4000);
    wait_idle(); issue(1'b1, 1, 2, 'hBFFF);
    wait_idle(); issue(1'b1, 1, 2, 'hFFFF);

    // All-zero row falls back to the last state.
    wait_idle();
    row_const(1, 2, 0);
    issue(1'b1, 1, 2, 0);

    // Start held high continuously.
    wait_idle();
    row_const(1, 2, 'h4000);
    for (int i = 0; i < 10; i++) issue(1'b1, 1, 2, 'h4000);

    // Reset in cycle 2 of a scan, then a fresh request.
    wait_idle();
    issue(1'b1, 1, 2, 'hFFFF);
    issue(1'b0, 0, 0, 0);
    rst   = 1'b1;
    start = 1'b0;
    step();
    rst = 1'b0;
    next_idle = cyc;
    issue(1'b1, 1, 2, 'hBFFF);

    // Randomized requests against randomized tables.
    for (int i = 0; i < 60; i++) begin
      wait_idle();
      if ($urandom_range(0, 3) == 0) randomize_table();
      case ($urandom_range(0, 5))
        0:       r = 0;
        1:       r = 'hFFFF;
        default: r = $urandom_range(0, 65535);
      endcase
      issue(1'b1, $urandom_range(0, 2), $urandom_range(0, 3), r);
      repeat ($urandom_range(0, 2)) issue(1'b0, 0, 0, 0);
    end

    wait_idle();
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
